// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the oversampled SPI slave front end.
package spi_slave_pkg;

  localparam int SPI_BYTE_W = 8;

  typedef logic [SPI_BYTE_W-1:0] spi_byte_t;
  typedef logic [2:0]            spi_bitcnt_t;

  localparam spi_byte_t SPI_IDLE_BYTE = 8'hFF;

  typedef enum logic {
    ST_IDLE,
    ST_ACTIVE
  } spi_frame_e;

endpackage

// File: rtl/spi_slave_frontend_if.sv
// Pin and byte-stream bundle of the SPI slave front end.
// Optional stats ports appear under SPI_SLAVE_FRONTEND_STATS_EN.
interface spi_slave_frontend_if;

  logic                  SPI_CLK;
  logic                  SPI_MOSI;
  logic                  SPI_SS;
  logic                  SPI_MISO;
  spi_slave_pkg::spi_byte_t rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  spi_slave_pkg::spi_byte_t tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic                  frame_active;
  logic                  rx_overflow;
`ifdef SPI_SLAVE_FRONTEND_STATS_EN
  logic [15:0]           rx_byte_count;
  logic [15:0]           rx_drop_count;
`endif

  modport slave (
    input  SPI_CLK, SPI_MOSI, SPI_SS,
    input  rx_ready, tx_data, tx_valid,
    output SPI_MISO, rx_data, rx_valid,
    output tx_ready, frame_active, rx_overflow
`ifdef SPI_SLAVE_FRONTEND_STATS_EN
    , output rx_byte_count, rx_drop_count
`endif
  );

  modport master (
    output SPI_CLK, SPI_MOSI, SPI_SS,
    output rx_ready, tx_data, tx_valid,
    input  SPI_MISO, rx_data, rx_valid,
    input  tx_ready, frame_active, rx_overflow
`ifdef SPI_SLAVE_FRONTEND_STATS_EN
    , input rx_byte_count, rx_drop_count
`endif
  );

endinterface

// File: rtl/spi_rx_fifo.sv
// First-word-fall-through byte FIFO; pointers carry an extra wrap bit.
module spi_rx_fifo
  import spi_slave_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push_i,
  input  spi_byte_t din_i,
  input  logic      pop_i,
  output spi_byte_t dout_o,
  output logic      full_o,
  output logic      empty_o,
  output logic      drop_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = 1;

  logic [AW:0] wr_q;
  logic [AW:0] rd_q;
  spi_byte_t   mem_q [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop_i & ~empty_o;
  // A pop in the same cycle frees the slot for a push into a full FIFO.
  assign do_push = push_i & (~full_o | do_pop);
  assign drop_o  = push_i & ~do_push;
  assign dout_o  = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + ONE;
      if (do_pop)  rd_q <= rd_q + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/spi_slave_frontend.sv
// Mode-0 SPI slave oversampled in the clk domain; no logic on SPI_CLK.
// Define SPI_SLAVE_FRONTEND_STATS_EN to add byte/drop counters.
module spi_slave_frontend
  import spi_slave_pkg::*;
#(
  parameter int        SYNC_STAGES   = 2,
  parameter int        RX_FIFO_DEPTH = 4,
  parameter spi_byte_t TX_IDLE_BYTE  = SPI_IDLE_BYTE
) (
  input logic           clk,
  input logic           rst,
  spi_slave_frontend_if.slave bus
);

  logic [SYNC_STAGES-1:0] sck_sync_q;
  logic [SYNC_STAGES-1:0] ss_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic sck_d_q;
  logic ss_d_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync_q  <= '0;
      ss_sync_q   <= '1;
      mosi_sync_q <= '0;
      sck_d_q     <= 1'b0;
      ss_d_q      <= 1'b1;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], bus.SPI_CLK};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], bus.SPI_SS};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.SPI_MOSI};
      sck_d_q     <= sck_sync_q[SYNC_STAGES-1];
      ss_d_q      <= ss_sync_q[SYNC_STAGES-1];
    end
  end

  logic sck_s, ss_s, mosi_s;
  logic sck_rise, sck_fall, ss_fall, ss_rise;

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign ss_s     = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_d_q;
  assign sck_fall = ~sck_s & sck_d_q;
  assign ss_fall  = ~ss_s & ss_d_q;
  assign ss_rise  = ss_s & ~ss_d_q;

  spi_frame_e  state_q;
  spi_bitcnt_t bitcnt_q;
  logic [6:0]  rx_shift_q;
  spi_byte_t   tx_shift_q;
  spi_byte_t   hold_q;
  logic        held_q;
  logic        push_q;
  spi_byte_t   push_byte_q;
  logic        ovf_q;

  spi_byte_t rx_word;
  spi_byte_t tx_src;
  logic      tx_cap;
  logic      tx_load;
  logic      fifo_pop;
  logic      fifo_empty;
  logic      fifo_full;
  logic      fifo_drop;

  assign rx_word = {rx_shift_q, mosi_s};
  assign tx_src  = held_q ? hold_q : TX_IDLE_BYTE;
  assign tx_cap  = bus.tx_valid & ~held_q;
  // Shift register reloads at frame start and at each byte boundary fall.
  assign tx_load = (state_q == ST_IDLE && ss_fall) ||
                   (state_q == ST_ACTIVE && !ss_rise && !sck_rise &&
                    sck_fall && bitcnt_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bitcnt_q    <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= TX_IDLE_BYTE;
      hold_q      <= '0;
      held_q      <= 1'b0;
      push_q      <= 1'b0;
      push_byte_q <= '0;
      ovf_q       <= 1'b0;
    end else begin
      push_q <= 1'b0;
      ovf_q  <= fifo_drop;
      held_q <= (held_q & ~tx_load) | tx_cap;
      if (tx_cap) hold_q <= bus.tx_data;
      if (tx_load) tx_shift_q <= tx_src;
      unique case (state_q)
        ST_IDLE: begin
          if (ss_fall) begin
            state_q    <= ST_ACTIVE;
            bitcnt_q   <= '0;
            rx_shift_q <= '0;
          end
        end
        ST_ACTIVE: begin
          if (ss_rise) begin
            state_q    <= ST_IDLE;
            bitcnt_q   <= '0;
            rx_shift_q <= '0;
            tx_shift_q <= TX_IDLE_BYTE;
          end else if (sck_rise) begin
            rx_shift_q <= rx_word[6:0];
            bitcnt_q   <= bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
              push_q      <= 1'b1;
              push_byte_q <= rx_word;
            end
          end else if (sck_fall && bitcnt_q != '0) begin
            tx_shift_q <= {tx_shift_q[6:0], 1'b0};
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign fifo_pop = ~fifo_empty & bus.rx_ready;

  spi_rx_fifo #(
    .DEPTH (RX_FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_q),
    .din_i   (push_byte_q),
    .pop_i   (fifo_pop),
    .dout_o  (bus.rx_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .drop_o  (fifo_drop)
  );

  assign bus.SPI_MISO     = tx_shift_q[7];
  assign bus.rx_valid     = ~fifo_empty;
  assign bus.tx_ready     = ~held_q;
  assign bus.frame_active = ~ss_s;
  assign bus.rx_overflow  = ovf_q;

`ifdef SPI_SLAVE_FRONTEND_STATS_EN
  logic [15:0] byte_cnt_q;
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (push_q)    byte_cnt_q <= byte_cnt_q + 16'd1;
      if (fifo_drop) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign bus.rx_byte_count = byte_cnt_q;
  assign bus.rx_drop_count = drop_cnt_q;
`else
  logic unused_full;
  assign unused_full = fifo_full;
`endif

endmodule

// File: doc/spi_slave_frontend.md
Name: spi_slave_frontend

Overview:
Oversampled SPI mode-0 slave front end that sits directly between the board SPI pins and spi_soc's byte-level command interface.
- Resynchronises SPI_CLK/SPI_MOSI/SPI_SS into the system clock domain.
- Deserialises MOSI into bytes buffered in a small RX FIFO.
- Serialises TX bytes onto SPI_MISO.
- No logic runs on SPI_CLK itself, which removes the BUFR clock domain from the SoC.

Parameters:
SYNC_STAGES, 2, synchroniser flops per SPI input (min 2)
RX_FIFO_DEPTH, 4, RX FIFO entries (power of two, ≥2)
TX_IDLE_BYTE, 8'hFF, byte shifted out when no TX byte is held

Ports:
clk  input  1  system clock
rst  input  1  reset, synchronous, active-high
SPI_CLK  input  1  SPI clock pin, asynchronous to clk, mode 0 (CPOL=0, CPHA=0)
SPI_MOSI  input  1  master-out data pin
SPI_SS  input  1  chip select pin, active-low
SPI_MISO  output  1  slave-out data pin
rx_data  output  8  FIFO head byte
rx_valid  output  1  FIFO non-empty
rx_ready  input  1  consumer pops the head when rx_valid&rx_ready
tx_data  input  8  byte to send
tx_valid  input  1  producer offers tx_data
tx_ready  output  1  TX holding register empty
frame_active  output  1  synchronised SS asserted
rx_overflow  output  1  one-cycle pulse when a completed byte is dropped (FIFO full)

Behaviour:
Interface decisions:
- One clock (clk); reset is synchronous and active-high (rst). All logic is in the clk domain.

Reset:
- SPI_MISO=TX_IDLE_BYTE[7], rx_valid=0, rx_data=0, tx_ready=1, frame_active=0, rx_overflow=0.
- FIFO empty, bit counter 0.
- Synchronisers reset to idle values: SCK=0, SS=1.

Input synchronisation:
- Each pin passes through SYNC_STAGES flops, then one extra register for edge detection.
- sck_rise / sck_fall / ss_fall / ss_rise are single-cycle pulses, SYNC_STAGES+1 cycles after the pin edge.
- Supported SCK frequency: ≤ clk/(2*(SYNC_STAGES+3)).

Frame states:
- IDLE → ACTIVE on ss_fall:
  - Clear bit counter.
  - Load the TX shift register from the holding register if full (holding register empties), else from TX_IDLE_BYTE.
  - Drive SPI_MISO = shift[7].
- ACTIVE:
  - sck_rise: rx_shift <= {rx_shift[6:0], MOSI}; bitcnt++.
  - On the 8th rise (bitcnt 7→0 wrap): push the byte into the FIFO the next cycle. If the FIFO is full, drop the byte and pulse rx_overflow.
  - sck_fall: if bitcnt≠0, shift TX left and drive the new MSB. If bitcnt==0 (byte boundary), reload TX as in IDLE→ACTIVE.
- ACTIVE → IDLE on ss_rise:
  - Discard any partial RX byte and reset bitcnt.
  - Drive SPI_MISO = TX_IDLE_BYTE[7].
  - A holding-register byte not yet loaded is kept.
- SCK edges while IDLE are ignored.
- sck_rise and ss_rise in the same cycle: ss_rise wins; the bit is discarded.

TX holding register:
- tx_ready = !held.
- Captured on tx_valid&tx_ready.
- Load into the shift register and capture of a new byte may occur in the same cycle.

RX FIFO:
- First-word-fall-through.
- Push and pop in the same cycle when full: the pop frees a slot and the push is accepted (no overflow).

Other:
- frame_active tracks synchronised !SS.
- Reset mid-frame returns everything to reset values; the next frame starts only on a fresh ss_fall.

Optional Feature:
SPI_SLAVE_FRONTEND_STATS_EN:
- When defined, adds outputs rx_byte_count[15:0] and rx_drop_count[15:0]:
  - rx_byte_count increments on every completed byte, including dropped ones.
  - rx_drop_count increments on every rx_overflow.
  - Both wrap modulo 2^16 and reset to 0.
- When undefined, these ports and counters are absent; all other behaviour is identical.

Decomposition:
Package spi_slave_pkg:
- SPI_BYTE_W=8.
- typedef spi_byte_t (logic [7:0]).
- SPI_IDLE_BYTE=8'hFF.
- Bit-counter typedef, logic [2:0].

Sub-module spi_rx_fifo:
- Parameterised depth.
- FWFT.
- push/pop/full/empty.
- Pointer-wrap with extra MSB.

Test Plan:
- Reset, no activity → rx_valid=0, tx_ready=1, SPI_MISO=1, frame_active=0.
- SS low, master sends 8'hA5 at clk/16, rx_ready=1 → rx_data=8'hA5 with rx_valid for 1 cycle; master receives 8'hFF.
- tx_data=8'h3C preloaded before SS low; master clocks 2 bytes → master reads 8'h3C then 8'hFF; tx_ready returns to 1 at ss_fall+1.
- rx_ready=0; master sends 5 bytes 8'h01..8'h05 (depth 4) → FIFO holds 01..04; one rx_overflow pulse on byte 05; with STATS_EN, rx_byte_count=5 and rx_drop_count=1.
- SS raised after 3 bits of 8'hFF → no FIFO push; next frame sends 8'h81 → rx_data=8'h81 (no bit leakage).
- rst asserted mid-byte → all outputs return to reset values; a subsequent full frame of 8'h5A is received correctly.
